core_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the NPC datapath. Owns the PC register and issues the instruction-fetch and load/store memory handshakes.
- Holds the fetched instruction stable while decode/ALU/writeback logic settles combinationally.
- Uses the writeback stage's branch/jump resolution (is_jal, is_jalr, take_branch, targets) to pick the next PC.
- Pulses the register-file and CSR write enables exactly once per retired instruction.

---
 rtl/core_seq_ctrl_pkg.sv | 45 ++++
 rtl/core_seq_ctrl_timeout.sv | 35 +++
 rtl/core_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_core_seq_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_seq_ctrl_pkg.sv
// Shared encodings for the multi-cycle sequencer: state codes, RV32 opcode
// classes, and the fixed ebreak/nop instruction words.
package core_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_WB    = 3'd4,
    ST_HALT  = 3'd5,
    ST_ERROR = 3'd6
  } state_e;

  localparam logic [6:0] INST_LUI   = 7'b0110111;
  localparam logic [6:0] INST_AUIPC = 7'b0010111;
  localparam logic [6:0] INST_JAL   = 7'b1101111;
  localparam logic [6:0] INST_JALR  = 7'b1100111;
  localparam logic [6:0] INST_B     = 7'b1100011;
  localparam logic [6:0] INST_LW    = 7'b0000011;
  localparam logic [6:0] INST_S     = 7'b0100011;
  localparam logic [6:0] INST_I     = 7'b0010011;
  localparam logic [6:0] INST_R     = 7'b0110011;
  localparam logic [6:0] INST_CSR   = 7'b1110011;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_NOP    = 32'h0000_0013;

  // SYSTEM with func3==0 covers ecall/ebreak/mret, which never write a register.
  function automatic logic inst_writes_rf(input logic [31:0] ins);
    logic we;
    case (ins[6:0])
      INST_LUI, INST_AUIPC, INST_JAL, INST_JALR,
      INST_LW, INST_R, INST_I: we = 1'b1;
      INST_CSR:                we = (ins[14:12] != 3'b000);
      default:                 we = 1'b0;
    endcase
    return we;
  endfunction

  function automatic logic inst_writes_csr(input logic [31:0] ins);
    return (ins[6:0] == INST_CSR) && (ins[14:12] != 3'b000);
  endfunction

endpackage

// File: rtl/core_seq_ctrl_timeout.sv
// Wait-cycle counter shared by the fetch and data-memory handshakes; expired
// is raised while the current wait is the LIMIT-th consecutive one.
module core_seq_timeout #(
  parameter logic [7:0] LIMIT = 8'd255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = inc_i && (cnt_q == (LIMIT - 8'd1));

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle sequencer: owns the PC, drives fetch and load/store handshakes,
// and pulses writeback enables once per retired instruction.
// Optional performance counters are enabled by defining CORE_SEQ_PERF_CNT_EN.
module core_seq_ctrl
  import core_seq_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h8000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ifu_req,
  output logic [31:0] ifu_addr,
  input  logic        ifu_rvalid,
  input  logic [31:0] ifu_rdata,
  input  logic        ifu_err,
  output logic        lsu_req,
  output logic        lsu_wen,
  input  logic        lsu_rvalid,
  input  logic        lsu_err,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic        take_branch,
  input  logic [31:0] jal_target,
  input  logic [31:0] jalr_target,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        rf_we,
  output logic        csr_we,
  output logic        halt,
  output logic        err,
  output logic [63:0] perf_cycle,
  output logic [63:0] perf_instret
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        tmo_clr, tmo_inc, tmo_expired;

  // FETCH and MEM are never active together, so one counter serves both.
  assign tmo_clr = (state_q != ST_FETCH) && (state_q != ST_MEM);
  assign tmo_inc = ((state_q == ST_FETCH) && !ifu_rvalid) ||
                   ((state_q == ST_MEM)   && !lsu_rvalid);

  core_seq_timeout #(
    .LIMIT (TIMEOUT_CYCLES[7:0])
  ) u_timeout (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .clr_i     (tmo_clr),
    .inc_i     (tmo_inc),
    .expired_o (tmo_expired)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    ifu_req = 1'b0;
    lsu_req = 1'b0;
    lsu_wen = 1'b0;
    rf_we   = 1'b0;
    csr_we  = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        ifu_req = 1'b1;
        if (ifu_rvalid) begin
          if (ifu_err) begin
            state_d = ST_ERROR;
          end else begin
            inst_d  = ifu_rdata;
            state_d = ST_EXEC;
          end
        end else if (tmo_expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_EXEC: begin
        if (inst_q == INST_EBREAK) begin
          state_d = ST_HALT;
        end else if ((inst_q[6:0] == INST_LW) || (inst_q[6:0] == INST_S)) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        lsu_req = 1'b1;
        lsu_wen = (inst_q[6:0] == INST_S);
        if (lsu_rvalid) begin
          state_d = lsu_err ? ST_ERROR : ST_WB;
        end else if (tmo_expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_WB: begin
        rf_we   = inst_writes_rf(inst_q);
        csr_we  = inst_writes_csr(inst_q);
        state_d = ST_FETCH;
        if (is_jalr) begin
          pc_d = jalr_target;
        end else if (is_jal || take_branch) begin
          pc_d = jal_target;
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end
      ST_HALT:  state_d = ST_HALT;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= INST_NOP;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  assign ifu_addr = pc_q;
  assign pc       = pc_q;
  assign inst     = inst_q;
  assign halt     = (state_q == ST_HALT);
  assign err      = (state_q == ST_ERROR);

`ifdef CORE_SEQ_PERF_CNT_EN
  logic [63:0] perf_cycle_q, perf_instret_q;
  logic        core_active;

  assign core_active = (state_q != ST_IDLE) && (state_q != ST_HALT) &&
                       (state_q != ST_ERROR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycle_q   <= 64'h0;
      perf_instret_q <= 64'h0;
    end else begin
      if (core_active) begin
        perf_cycle_q <= perf_cycle_q + 64'd1;
      end
      if (state_q == ST_WB) begin
        perf_instret_q <= perf_instret_q + 64'd1;
      end
    end
  end

  assign perf_cycle   = perf_cycle_q;
  assign perf_instret = perf_instret_q;
`else
  assign perf_cycle   = 64'h0;
  assign perf_instret = 64'h0;
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Self-checking bench for core_seq_ctrl: directed scenarios plus randomized
// instruction streams checked against an instruction-level reference model.
module tb_core_seq_ctrl;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int          TMO    = 4;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef CORE_SEQ_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  // Instruction catalogue: 0 addi,1 lui,2 auipc,3 jal,4 jalr,5 beq,6 lw,
  // 7 sw,8 add,9 csrrw,10 csrrs,11 ecall,12 fence.
  localparam int NI = 13;
  localparam logic [31:0] TBL_W [NI] = '{
    32'h0050_0093, 32'h1234_5137, 32'h0000_1197, 32'h0080_00ef,
    32'h0000_8067, 32'h0000_0463, 32'h0001_2283, 32'h0051_2223,
    32'h0020_81b3, 32'h3052_9073, 32'h3000_2373, 32'h0000_0073,
    32'h0000_000f};
  localparam bit TBL_RF  [NI] = '{1,1,1,1,1,0,1,0,1,1,1,0,0};
  localparam bit TBL_CSR [NI] = '{0,0,0,0,0,0,0,0,0,1,1,0,0};
  localparam bit TBL_MEM [NI] = '{0,0,0,0,0,0,1,1,0,0,0,0,0};
  localparam bit TBL_ST  [NI] = '{0,0,0,0,0,0,0,1,0,0,0,0,0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req, ifu_rvalid, ifu_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req, lsu_wen, lsu_rvalid, lsu_err;
  logic        is_jal, is_jalr, take_branch;
  logic [31:0] jal_target, jalr_target;
  logic [31:0] inst, pc;
  logic        rf_we, csr_we, halt, err;
  logic [63:0] perf_cycle, perf_instret;

  int              n_tests = 0;
  int              n_fail  = 0;
  logic [31:0]     m_pc;
  longint unsigned m_act, m_ret;

  always #5 clk = ~clk;

  core_seq_ctrl #(
    .RESET_PC       (RST_PC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ifu_req      (ifu_req),
    .ifu_addr     (ifu_addr),
    .ifu_rvalid   (ifu_rvalid),
    .ifu_rdata    (ifu_rdata),
    .ifu_err      (ifu_err),
    .lsu_req      (lsu_req),
    .lsu_wen      (lsu_wen),
    .lsu_rvalid   (lsu_rvalid),
    .lsu_err      (lsu_err),
    .is_jal       (is_jal),
    .is_jalr      (is_jalr),
    .take_branch  (take_branch),
    .jal_target   (jal_target),
    .jalr_target  (jalr_target),
    .inst         (inst),
    .pc           (pc),
    .rf_we        (rf_we),
    .csr_we       (csr_we),
    .halt         (halt),
    .err          (err),
    .perf_cycle   (perf_cycle),
    .perf_instret (perf_instret)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_perf(input longint unsigned v);
    return PERF_EN ? 64'(v) : 64'h0;
  endfunction

  // Leave a cycle during which the sequencer is busy (counts toward perf_cycle).
  task automatic step_active();
    @(negedge clk);
    m_act++;
  endtask

  task automatic clear_inputs();
    ifu_rvalid = 1'b0; ifu_rdata = 32'h0; ifu_err = 1'b0;
    lsu_rvalid = 1'b0; lsu_err = 1'b0;
    is_jal = 1'b0; is_jalr = 1'b0; take_branch = 1'b0;
    jal_target = 32'h0; jalr_target = 32'h0;
  endtask

  // Reset, check reset state, step through the IDLE bubble; returns in FETCH.
  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_pc = RST_PC; m_act = 0; m_ret = 0;
    chk("rst_pc", pc, RST_PC);
    chk("rst_inst", inst, NOP);
    chk("rst_ifu_req", ifu_req, 0);
    chk("rst_lsu_req", lsu_req, 0);
    chk("rst_we", {rf_we, csr_we}, 0);
    chk("rst_halt_err", {halt, err}, 0);
    chk("rst_perf", perf_cycle | perf_instret, 0);
    @(negedge clk);
  endtask

  // Run one instruction from its first FETCH cycle through WB.
  task automatic run_instr(input int idx, input int fwait, input int mwait,
                           input bit jal, input bit jalr, input bit br,
                           input logic [31:0] jt, input logic [31:0] jrt);
    chk("perf_cycle", perf_cycle, exp_perf(m_act));
    chk("perf_instret", perf_instret, exp_perf(m_ret));
    for (int i = 0; i <= fwait; i++) begin
      chk("fetch_req", ifu_req, 1);
      chk("fetch_addr", ifu_addr, m_pc);
      ifu_rvalid = (i == fwait);
      ifu_rdata  = (i == fwait) ? TBL_W[idx] : $urandom;
      step_active();
    end
    ifu_rvalid = 1'b0;
    ifu_rdata  = $urandom;
    chk("exec_req", {ifu_req, lsu_req}, 0);
    chk("exec_inst", inst, TBL_W[idx]);
    chk("exec_we", {rf_we, csr_we}, 0);
    is_jal = jal; is_jalr = jalr; take_branch = br;
    jal_target = jt; jalr_target = jrt;
    step_active();
    if (TBL_MEM[idx]) begin
      for (int j = 0; j <= mwait; j++) begin
        chk("mem_req", lsu_req, 1);
        chk("mem_wen", lsu_wen, TBL_ST[idx]);
        chk("mem_rf_we", rf_we, 0);
        lsu_rvalid = (j == mwait);
        step_active();
      end
      lsu_rvalid = 1'b0;
    end
    chk("wb_req", {ifu_req, lsu_req}, 0);
    chk("wb_rf_we", rf_we, TBL_RF[idx]);
    chk("wb_csr_we", csr_we, TBL_CSR[idx]);
    step_active();
    m_ret++;
    if (jalr)           m_pc = jrt;
    else if (jal || br) m_pc = jt;
    else                m_pc = m_pc + 32'd4;
    is_jal = 1'b0; is_jalr = 1'b0; take_branch = 1'b0;
    chk("next_pc", pc, m_pc);
  endtask

  // Zero-wait fetch of a word, then step out of EXEC.
  task automatic fetch_exec(input logic [31:0] w);
    ifu_rvalid = 1'b1;
    ifu_rdata  = w;
    step_active();
    ifu_rvalid = 1'b0;
    chk("fx_inst", inst, w);
    step_active();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] saved_inst;
    rst_n = 1'b0;
    clear_inputs();
    do_reset();

    // addi x1,x0,5 with zero-wait fetch
    chk("addi_addr", ifu_addr, 32'h8000_0000);
    run_instr(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("addi_pc", pc, 32'h8000_0004);

    // lw with three MEM cycles
    run_instr(6, 0, 2, 0, 0, 0, 32'h0, 32'h0);

    // taken branch, then jalr overriding the branch
    run_instr(5, 0, 0, 0, 0, 1, 32'h8000_0100, 32'h0);
    chk("br_addr", ifu_addr, 32'h8000_0100);
    run_instr(5, 0, 0, 0, 1, 1, 32'h8000_0300, 32'h8000_0200);
    chk("jalr_addr", ifu_addr, 32'h8000_0200);

    // randomized instruction stream, waits up to TMO-1 (boundary)
    for (int k = 0; k < 40; k++) begin
      logic [31:0] jt, jrt;
      logic [2:0]  ctl;
      jt  = $urandom & 32'hFFFF_FFFC;
      jrt = $urandom & 32'hFFFF_FFFC;
      ctl = 3'($urandom_range(0, 7));
      run_instr(int'($urandom_range(0, NI - 1)), int'($urandom_range(0, TMO - 1)),
                int'($urandom_range(0, TMO - 1)), ctl[0], ctl[1], ctl[2], jt, jrt);
    end

    // PC wrap at the top of the address space
    run_instr(4, 0, 0, 0, 1, 0, 32'h0, 32'hFFFF_FFFC);
    chk("top_addr", ifu_addr, 32'hFFFF_FFFC);
    run_instr(8, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("wrap_addr", ifu_addr, 32'h0000_0000);
    chk("wrap_instret", perf_instret, exp_perf(m_ret));

    // fetch timeout, then a late response that must be ignored
    for (int i = 0; i < TMO; i++) begin
      chk("tmo_req", ifu_req, 1);
      step_active();
    end
    chk("tmo_err", err, 1);
    chk("tmo_req_off", ifu_req, 0);
    chk("tmo_pc", pc, 32'h0);
    ifu_rvalid = 1'b1;
    ifu_rdata  = EBREAK;
    @(negedge clk);
    ifu_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    chk("late_err", err, 1);
    chk("late_halt", halt, 0);
    chk("late_inst", inst, TBL_W[8]);
    chk("late_pc", pc, 32'h0);
    chk("late_req", {ifu_req, lsu_req}, 0);
    chk("err_perf", perf_cycle, exp_perf(m_act));

    // reset clears err; reset asserted mid-fetch drops the request at once
    do_reset();
    chk("rerr_err", err, 0);
    chk("mid_req", ifu_req, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_req", ifu_req, 0);
    do_reset();

    // ebreak halts and stays halted
    run_instr(0, 1, 0, 0, 0, 0, 32'h0, 32'h0);
    ifu_rvalid = 1'b1;
    ifu_rdata  = EBREAK;
    step_active();
    ifu_rvalid = 1'b0;
    chk("ebreak_we", {rf_we, csr_we}, 0);
    step_active();
    for (int i = 0; i < 4; i++) begin
      chk("halt", halt, 1);
      chk("halt_req", {ifu_req, lsu_req}, 0);
      chk("halt_pc", pc, m_pc);
      lsu_rvalid = 1'(i[0]);
      ifu_rvalid = 1'(i[0]);
      @(negedge clk);
    end
    lsu_rvalid = 1'b0;
    ifu_rvalid = 1'b0;
    chk("halt_err", err, 0);
    chk("halt_perf", perf_cycle, exp_perf(m_act));
    do_reset();
    chk("unhalt", halt, 0);

    // fetch bus error keeps the previous instruction
    run_instr(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    saved_inst = inst;
    ifu_rvalid = 1'b1; ifu_err = 1'b1; ifu_rdata = TBL_W[0];
    step_active();
    ifu_rvalid = 1'b0; ifu_err = 1'b0;
    chk("ferr_err", err, 1);
    chk("ferr_inst", inst, saved_inst);
    chk("ferr_req", ifu_req, 0);
    do_reset();

    // data bus error on a load
    fetch_exec(TBL_W[6]);
    chk("lerr_req", lsu_req, 1);
    lsu_rvalid = 1'b1; lsu_err = 1'b1;
    step_active();
    lsu_rvalid = 1'b0; lsu_err = 1'b0;
    chk("lerr_err", err, 1);
    chk("lerr_out", {lsu_req, rf_we}, 0);
    do_reset();

    // store that never completes times out in MEM
    fetch_exec(TBL_W[7]);
    for (int i = 0; i < TMO; i++) begin
      chk("mtmo_req", lsu_req, 1);
      chk("mtmo_wen", lsu_wen, 1);
      step_active();
    end
    chk("mtmo_err", err, 1);
    chk("mtmo_req_off", lsu_req, 0);
    chk("mtmo_pc", pc, RST_PC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
